// File: rtl/pc_sequencer_if.sv
// Handshake and status bundle between the PC sequencer and its environment
// (run control, instruction memory port, execute stage).
interface pc_sequencer_if;
  logic        Run;
  logic [31:0] StartPC;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] Instr;
  logic [31:0] IR;
  logic        BranchValid;
  logic        BranchTaken;
  logic [31:0] BranchImm;
  logic        Stall;
  logic [31:0] PC;
  logic        PCSel;
  logic        Halted;
  logic        Fault;

  modport master (
    input  Run, StartPC,
    input  IMemAck, Instr,
    input  BranchValid, BranchTaken,
    input  BranchImm, Stall,
    output IMemReq, IMemAddr, IR,
    output PC, PCSel, Halted, Fault
  );

  modport slave (
    output Run, StartPC,
    output IMemAck, Instr,
    output BranchValid, BranchTaken,
    output BranchImm, Stall,
    input  IMemReq, IMemAddr, IR,
    input  PC, PCSel, Halted, Fault
  );
endinterface

// File: rtl/pc_sequencer.sv
// Multicycle fetch/branch controller owning the program counter:
// fetch via req/ack, resolve next PC from execute stage, halt/fault status.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MAX_WAIT  = 15,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic          CLK,
  input  logic          MasterReset,
  pc_sequencer_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  localparam int WW = $clog2(MAX_WAIT + 2);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  logic [2:0]    state;
  logic [WW-1:0] wait_cnt;
  logic [31:0]   pc;
  logic [31:0]   ir;
  logic          pcsel;
  logic [31:0]   next_pc;

  assign next_pc = bus.BranchTaken ? pc + bus.BranchImm
                                   : pc + 32'd4;

  always_ff @(posedge CLK or posedge MasterReset) begin
    if (MasterReset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      pc       <= RESET_PC;
      ir       <= '0;
      pcsel    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.Run) begin
            pc       <= bus.StartPC;
            wait_cnt <= '0;
            state    <= (bus.StartPC[1:0] != 2'b00) ? S_FAULT : S_FETCH;
          end
        end
        S_FETCH: begin
          // an ack in the last window cycle still wins over the timeout
          if (bus.IMemAck) begin
            ir    <= bus.Instr;
            state <= (bus.Instr == HALT_WORD) ? S_DONE : S_EXEC;
          end else if (wait_cnt == WMAX) begin
            state <= S_FAULT;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        S_EXEC: begin
          if (bus.BranchValid && !bus.Stall) begin
            pc       <= next_pc;
            pcsel    <= bus.BranchTaken;
            wait_cnt <= '0;
            if (next_pc[1:0] != 2'b00)
              state <= S_FAULT;
            else if (bus.Run)
              state <= S_FETCH;
            else
              state <= S_IDLE;
          end
        end
        S_DONE: begin
          if (!bus.Run)
            state <= S_IDLE;
        end
        S_FAULT: begin
          state <= S_FAULT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.IMemReq  = (state == S_FETCH);
  assign bus.IMemAddr = pc;
  assign bus.PC       = pc;
  assign bus.IR       = ir;
  assign bus.PCSel    = pcsel;
  assign bus.Halted   = (state == S_DONE);
  assign bus.Fault    = (state == S_FAULT);

endmodule
